// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings and default datapath sizes.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned ARITH_WIDTH = 32;
  localparam int unsigned ARITH_SLICE = 8;

endpackage

// File: rtl/slice_serial_subtractor_sub_slice.sv
// One SLICE-bit ripple-borrow subtractor slice built from full_adder cells:
// a - b - borrow computed as a + ~b + ~borrow, borrow out is the inverted carry.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module sub_slice
  import arith_pkg::*;
#(
  parameter int unsigned SLICE = ARITH_SLICE
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             borrow_i,
  output logic [SLICE-1:0] s_o,
  output logic             borrow_o
);

  logic [SLICE:0] carry;

  assign carry[0] = ~borrow_i;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (~b_i[i]),
      .c_i (carry[i]),
      .s_o (s_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign borrow_o = ~carry[SLICE];

endmodule

// File: rtl/slice_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
//   state   | meaning
//   IDLE    | in_ready high, waiting for operands
//   RUN     | one slice per edge, borrow carried in borrow_q
//   DONE    | result presented until out_ready
module slice_serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH,
  parameter int unsigned SLICE = ARITH_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             borrow_sl;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_i      (a_sl),
    .b_i      (b_sl),
    .borrow_i (borrow_q),
    .s_o      (s_sl),
    .borrow_o (borrow_sl)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NSLICE; k++) begin
          if (cnt_q == CNT_W'(k)) diff_d[k*SLICE +: SLICE] = s_sl;
        end
        borrow_d = borrow_sl;
        cnt_d    = cnt_q + CNT_W'(1);
        // Flags must see the slice written on this same edge, hence diff_d.
        if (cnt_q == LAST_CNT) begin
          bout_d  = borrow_sl;
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule
